// File: rtl/reg_file_sb_if.sv
// Decode / write-back connection bundle for reg_file_sb.
//   wb_reg_*   : write-back stage write port (data, enable, address)
//   id_*       : decode-stage read addresses, source-use qualifiers, issue request
//   rf_*       : read data, stall, per-register busy flags returned to decode
// master = pipeline side (drives requests), slave = register file.
interface reg_file_sb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]      wb_reg_wdata;
  logic                       wb_reg_wea;
  logic [ADDR_WIDTH-1:0]      wb_reg_waddr;
  logic [ADDR_WIDTH-1:0]      id_rs1_addr;
  logic [ADDR_WIDTH-1:0]      id_rs2_addr;
  logic                       id_rs1_used;
  logic                       id_rs2_used;
  logic                       id_issue;
  logic [ADDR_WIDTH-1:0]      id_issue_waddr;
  logic [DATA_WIDTH-1:0]      rf_rs1_data;
  logic [DATA_WIDTH-1:0]      rf_rs2_data;
  logic                       rf_stall;
  logic [(2**ADDR_WIDTH)-1:0] rf_busy;

  modport master (
    output wb_reg_wdata, wb_reg_wea, wb_reg_waddr,
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output id_issue, id_issue_waddr,
    input  rf_rs1_data, rf_rs2_data, rf_stall, rf_busy
  );

  modport slave (
    input  wb_reg_wdata, wb_reg_wea, wb_reg_waddr,
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  id_issue, id_issue_waddr,
    output rf_rs1_data, rf_rs2_data, rf_stall, rf_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file with write-back bypass on both
// read ports and a per-register pending-write scoreboard (2-bit counters).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears registers and counters)
//   bus  : reg_file_sb_if.slave (write port, two read ports, issue/stall, busy)
// ZERO_REG=1 makes r0 a constant zero that is never written or scoreboarded.
module reg_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG   = 1'b0
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [1:0]            cnt  [NREG];
  logic [NREG-1:0]       inc;
  logic [NREG-1:0]       dec;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic                  issue_full;
  logic                  stall;
  logic                  wr_ok;

  // Writes to r0 are dropped when it is hardwired to zero.
  assign wr_ok = bus.wb_reg_wea && !(ZERO_REG && bus.wb_reg_waddr == '0);

  // A write-back only retires a pending count when one exists, so an
  // unscoreboarded write never underflows.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      dec[i] = bus.wb_reg_wea && (bus.wb_reg_waddr == ADDR_WIDTH'(i)) && (cnt[i] != 2'd0);
    end
  end

  // Effective pending = cnt - dec; it is nonzero unless cnt is 0, or cnt is 1
  // and that last write is arriving now (the bypass then supplies the data).
  always_comb begin
    rs1_pending = (cnt[bus.id_rs1_addr] != 2'd0) &&
                  !(dec[bus.id_rs1_addr] && cnt[bus.id_rs1_addr] == 2'd1);
    rs2_pending = (cnt[bus.id_rs2_addr] != 2'd0) &&
                  !(dec[bus.id_rs2_addr] && cnt[bus.id_rs2_addr] == 2'd1);
    issue_full  = bus.id_issue && (cnt[bus.id_issue_waddr] == 2'd3) &&
                  !dec[bus.id_issue_waddr];
    stall       = (bus.id_rs1_used && rs1_pending) ||
                  (bus.id_rs2_used && rs2_pending) ||
                  issue_full;
  end

  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      inc[i] = bus.id_issue && !stall && (bus.id_issue_waddr == ADDR_WIDTH'(i)) &&
               !(ZERO_REG && i == 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 2'd1;
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wb_reg_waddr] <= bus.wb_reg_wdata;
    end
  end

  always_comb begin
    if (ZERO_REG && bus.id_rs1_addr == '0) begin
      bus.rf_rs1_data = '0;
    end else if (bus.wb_reg_wea && bus.wb_reg_waddr == bus.id_rs1_addr) begin
      bus.rf_rs1_data = bus.wb_reg_wdata;
    end else begin
      bus.rf_rs1_data = regs[bus.id_rs1_addr];
    end

    if (ZERO_REG && bus.id_rs2_addr == '0) begin
      bus.rf_rs2_data = '0;
    end else if (bus.wb_reg_wea && bus.wb_reg_waddr == bus.id_rs2_addr) begin
      bus.rf_rs2_data = bus.wb_reg_wdata;
    end else begin
      bus.rf_rs2_data = regs[bus.id_rs2_addr];
    end
  end

  always_comb begin
    bus.rf_busy = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      bus.rf_busy[i] = (cnt[i] != 2'd0);
    end
  end

  assign bus.rf_stall = stall;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] wdata;
  logic          wea;
  logic [AW-1:0] waddr, rs1, rs2, iw;
  logic          u1, u2, issue;

  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.wb_reg_wdata = wdata;  assign bus1.wb_reg_wdata = wdata;
  assign bus0.wb_reg_wea   = wea;    assign bus1.wb_reg_wea   = wea;
  assign bus0.wb_reg_waddr = waddr;  assign bus1.wb_reg_waddr = waddr;
  assign bus0.id_rs1_addr  = rs1;    assign bus1.id_rs1_addr  = rs1;
  assign bus0.id_rs2_addr  = rs2;    assign bus1.id_rs2_addr  = rs2;
  assign bus0.id_rs1_used  = u1;     assign bus1.id_rs1_used  = u1;
  assign bus0.id_rs2_used  = u2;     assign bus1.id_rs2_used  = u2;
  assign bus0.id_issue     = issue;  assign bus1.id_issue     = issue;
  assign bus0.id_issue_waddr = iw;   assign bus1.id_issue_waddr = iw;

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // Reference model: index 0 = plain r0, index 1 = hardwired-zero r0.
  logic [DW-1:0] mreg [2][NR];
  int            mcnt [2][NR];
  int n_vec = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NR; i++) begin
        mreg[z][i] = '0;
        mcnt[z][i] = 0;
      end
  endfunction

  function automatic bit m_dec(int z, int a);
    return wea && (int'(waddr) == a) && (mcnt[z][a] > 0);
  endfunction

  function automatic int m_eff(int z, int a);
    return mcnt[z][a] - (m_dec(z, a) ? 1 : 0);
  endfunction

  function automatic logic [DW-1:0] m_rd(int z, int a);
    if (z == 1 && a == 0) return '0;
    if (wea && int'(waddr) == a) return wdata;
    return mreg[z][a];
  endfunction

  function automatic bit m_stall(int z);
    return (u1 && m_eff(z, int'(rs1)) != 0) ||
           (u2 && m_eff(z, int'(rs2)) != 0) ||
           (issue && mcnt[z][int'(iw)] == 3 && !m_dec(z, int'(iw)));
  endfunction

  function automatic logic [NR-1:0] m_busy(int z);
    logic [NR-1:0] b;
    for (int i = 0; i < NR; i++) b[i] = (mcnt[z][i] != 0);
    return b;
  endfunction

  // Applies one clock edge to the model using the inputs held across it.
  function automatic void model_update();
    for (int z = 0; z < 2; z++) begin
      bit st = m_stall(z);
      int next_cnt [NR];
      for (int i = 0; i < NR; i++) begin
        int d = m_dec(z, i) ? 1 : 0;
        int n = (issue && !st && int'(iw) == i && !(z == 1 && i == 0)) ? 1 : 0;
        next_cnt[i] = mcnt[z][i] + n - d;
      end
      for (int i = 0; i < NR; i++) mcnt[z][i] = next_cnt[i];
      if (wea && !(z == 1 && waddr == '0)) mreg[z][int'(waddr)] = wdata;
    end
  endfunction

  task automatic cmp(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check(string tag);
    cmp({tag, "/z0.rs1"},  32'(bus0.rf_rs1_data), 32'(m_rd(0, int'(rs1))));
    cmp({tag, "/z0.rs2"},  32'(bus0.rf_rs2_data), 32'(m_rd(0, int'(rs2))));
    cmp({tag, "/z0.stall"}, 32'(bus0.rf_stall),   32'(m_stall(0)));
    cmp({tag, "/z0.busy"}, 32'(bus0.rf_busy),     32'(m_busy(0)));
    cmp({tag, "/z1.rs1"},  32'(bus1.rf_rs1_data), 32'(m_rd(1, int'(rs1))));
    cmp({tag, "/z1.rs2"},  32'(bus1.rf_rs2_data), 32'(m_rd(1, int'(rs2))));
    cmp({tag, "/z1.stall"}, 32'(bus1.rf_stall),   32'(m_stall(1)));
    cmp({tag, "/z1.busy"}, 32'(bus1.rf_busy),     32'(m_busy(1)));
  endtask

  task automatic drive(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                       logic [AW-1:0] a1, logic us1, logic [AW-1:0] a2, logic us2,
                       logic is, logic [AW-1:0] ia);
    wea = we; waddr = wa; wdata = wd;
    rs1 = a1; u1 = us1; rs2 = a2; u2 = us2;
    issue = is; iw = ia;
    #2;
  endtask

  // Model check before the edge, clock the edge, return to the negedge.
  task automatic cycle(string tag);
    check(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle bypass, then array read.
    drive(1, 3, 16'hBEEF, 3, 1, 0, 0, 0, 0);
    cmp("bypass_r3", 32'(bus0.rf_rs1_data), 32'h0000BEEF);
    cycle("wr_r3");
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    cmp("array_r3", 32'(bus0.rf_rs1_data), 32'h0000BEEF);
    cycle("rd_r3");

    // RAW hazard on r5 resolved by the write-back bypass.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5);
    cycle("iss_r5");
    drive(0, 0, 0, 0, 0, 5, 1, 0, 0);
    cmp("stall_r5", 32'(bus0.rf_stall), 32'd1);
    cmp("busy_r5", 32'(bus0.rf_busy[5]), 32'd1);
    cycle("haz_r5");
    drive(1, 5, 16'h1234, 0, 0, 5, 1, 0, 0);
    cmp("nostall_wb_r5", 32'(bus0.rf_stall), 32'd0);
    cmp("byp_r5", 32'(bus0.rf_rs2_data), 32'h00001234);
    cycle("wb_r5");
    drive(0, 0, 0, 0, 0, 5, 1, 0, 0);
    cmp("busy_r5_clear", 32'(bus0.rf_busy[5]), 32'd0);
    cycle("post_r5");

    // Counter saturation on r2.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
      cycle("iss_r2");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
    cmp("full_r2_stall", 32'(bus0.rf_stall), 32'd1);
    cycle("full_r2");
    drive(1, 2, 16'h2222, 0, 0, 0, 0, 1, 2);
    cmp("full_r2_wb_nostall", 32'(bus0.rf_stall), 32'd0);
    cycle("full_r2_wb");
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 16'h2220 + 16'(k), 0, 0, 0, 0, 0, 0);
      cycle("drain_r2");
    end

    // Simultaneous inc/dec on r4, then unscoreboarded write to r6.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4);
    cycle("iss_r4");
    drive(1, 4, 16'h4444, 0, 0, 0, 0, 1, 4);
    cycle("iss_wb_r4");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("busy_r4_held", 32'(bus0.rf_busy[4]), 32'd1);
    drive(1, 4, 16'h4445, 0, 0, 0, 0, 0, 0);
    cycle("wb_r4");
    drive(1, 6, 16'h5A5A, 0, 0, 0, 0, 0, 0);
    cycle("wr_r6");
    drive(0, 0, 0, 6, 1, 0, 0, 0, 0);
    cmp("r6_data", 32'(bus0.rf_rs1_data), 32'h00005A5A);
    cmp("r6_busy", 32'(bus0.rf_busy[6]), 32'd0);
    cycle("rd_r6");

    // Hardwired r0.
    drive(1, 0, 16'hFFFF, 0, 1, 0, 1, 1, 0);
    cmp("z1_r0_read", 32'(bus1.rf_rs1_data), 32'd0);
    cmp("z1_r0_nostall", 32'(bus1.rf_stall), 32'd0);
    cycle("r0_wr_iss");
    drive(0, 0, 0, 0, 1, 0, 1, 1, 0);
    cmp("z1_r0_busy", 32'(bus1.rf_busy[0]), 32'd0);
    cmp("z1_r0_read2", 32'(bus1.rf_rs2_data), 32'd0);
    cmp("z0_r0_busy", 32'(bus0.rf_busy[0]), 32'd1);
    cycle("r0_iss2");

    // Asynchronous reset in the middle of a cycle.
    drive(0, 0, 0, 3, 1, 6, 1, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    cmp("rst_rs1", 32'(bus0.rf_rs1_data), 32'd0);
    cmp("rst_busy", 32'(bus0.rf_busy), 32'd0);
    check("midrst");
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      drive(logic'($urandom_range(0, 9) < 4), AW'($urandom), DW'($urandom),
            AW'($urandom), logic'($urandom_range(0, 1)),
            AW'($urandom), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) < 6), AW'($urandom_range(0, 3)));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Register file on the receiving end of the write-back stage's write port: wdata / wea / waddr.
- Provides 8 x 16-bit architectural registers with two read ports for the decode stage.
- Read ports bypass the same-cycle write-back.
- An integrated pending-write scoreboard stalls decode when a source register still has an outstanding write in flight.

Parameters:
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 3, register address width; register count = 2**ADDR_WIDTH.
- ZERO_REG, 0, when 1, r0 reads as 0, ignores writes and is never scoreboarded.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_reg_wdata  input  DATA_WIDTH  write data from write-back stage.
- wb_reg_wea  input  1  write enable from write-back stage.
- wb_reg_waddr  input  ADDR_WIDTH  write address from write-back stage.
- id_rs1_addr  input  ADDR_WIDTH  read port 1 address.
- id_rs2_addr  input  ADDR_WIDTH  read port 2 address.
- id_rs1_used  input  1  decode instruction consumes rs1 (qualifies stall).
- id_rs2_used  input  1  decode instruction consumes rs2.
- id_issue  input  1  decode instruction issues this cycle and will write a register.
- id_issue_waddr  input  ADDR_WIDTH  destination of the issuing instruction.
- rf_rs1_data  output  DATA_WIDTH  read port 1 data (combinational).
- rf_rs2_data  output  DATA_WIDTH  read port 2 data (combinational).
- rf_stall  output  1  decode must hold; the issue is not accepted.
- rf_busy  output  2**ADDR_WIDTH  bit i = register i has pending count != 0.

Behaviour:
- Reset (async, rst=1): all registers 0, all pending counters 0.
  - Resulting outputs: rf_busy=0, rf_stall=0, rf_rsN_data=0 unless a write is being bypassed.
  - Reset mid-operation discards all pending state immediately.
- Write: on posedge clk, if wb_reg_wea, reg[wb_reg_waddr] <= wb_reg_wdata. Latency 1 cycle.
- Read: combinational from the array.
  - Bypass: if wb_reg_wea && wb_reg_waddr == id_rsN_addr, rf_rsN_data = wb_reg_wdata (write-through, same cycle).
  - ZERO_REG=1 and address 0: data = 0 and no bypass.
- Scoreboard: one 2-bit saturating-checked counter cnt[i] per register.
  - inc_i = id_issue && !rf_stall && id_issue_waddr == i.
  - dec_i = wb_reg_wea && wb_reg_waddr == i && cnt[i] != 0.
  - Update: inc and dec both set -> cnt unchanged; inc only -> +1; dec only -> -1.
  - Write with cnt[i] == 0 (unscoreboarded write): data still written, counter stays 0, no underflow.
- Effective pending for a source: eff(a) = cnt[a] - (1 if dec_a else 0).
  - A write-back arriving this cycle resolves its hazard via the bypass without stalling.
- rf_stall = (id_rs1_used && eff(rs1) != 0) || (id_rs2_used && eff(rs2) != 0) || (id_issue && cnt[id_issue_waddr] == 3 && !dec_(id_issue_waddr)).
  - The last term prevents counter overflow.
- While rf_stall = 1, id_issue is ignored and no counter increments.
- ZERO_REG=1: cnt[0] is held at 0; issues and writes to r0 are no-ops for the scoreboard and the array.
- All outputs other than stored state are combinational from the current inputs and state. No internal FSM beyond the counters.

Test Plan:
- Reset with rst pulsed mid-cycle after writes -> all reads 0 and rf_busy=0 immediately, before the next clk edge.
- Write r3=0xBEEF with wea=1 while rs1=3 in the same cycle -> rf_rs1_data=0xBEEF that cycle (bypass); next cycle 0xBEEF from the array.
- Issue dest r5, then next cycle rs2=5 with used=1 and no write-back -> rf_stall=1 and rf_busy[5]=1. Write-back r5=0x1234 arrives -> stall drops that cycle, rf_rs2_data=0x1234, and rf_busy[5]=0 after the edge.
- Issue r2 three times in consecutive cycles, then a fourth issue -> rf_stall=1 with cnt=3. Same cycle with a write-back to r2 -> no stall and cnt stays 3.
- Simultaneous issue and write-back to r4 with cnt=1 -> cnt remains 1 and rf_busy[4] stays 1. Unscoreboarded write to r6 with cnt=0 -> data written, cnt stays 0.
- ZERO_REG=1: write r0=0xFFFF and issue r0 -> reads of r0 return 0, rf_busy[0]=0, and the issue never stalls.
